// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and feeder FSM encoding.
package uart_pkg;

  localparam int UART_NB_DATA = 8;

  localparam logic [1:0] S_FEED_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED_START = 2'd1;
  localparam logic [1:0] S_FEED_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    FEED_IDLE  = S_FEED_IDLE,
    FEED_START = S_FEED_START,
    FEED_WAIT  = S_FEED_WAIT
  } feed_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Single-clock synchronous FIFO; read data is the current head, combinational.
// Push while full and pop while empty are ignored, so the count can never wrap.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int NB_DATA    = UART_NB_DATA,
  parameter int FIFO_DEPTH = 16,
  parameter int NB_ADDR    = $clog2(FIFO_DEPTH)  // derived; do not override
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [NB_DATA-1:0] wr_data,
  output logic [NB_DATA-1:0] rd_data,
  output logic [NB_ADDR:0]   count,
  output logic               empty,
  output logic               full
);

  localparam logic [NB_ADDR:0] DEPTH_C = (NB_ADDR + 1)'(FIFO_DEPTH);
  localparam logic [NB_ADDR:0] ONE_C   = (NB_ADDR + 1)'(1);
  localparam logic [NB_ADDR-1:0] PTR_ONE_C = NB_ADDR'(1);

  logic [NB_DATA-1:0] mem_r [FIFO_DEPTH];
  logic [NB_ADDR-1:0] wr_ptr_r;
  logic [NB_ADDR-1:0] rd_ptr_r;
  logic [NB_ADDR:0]   count_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign empty     = (count_r == {(NB_ADDR + 1){1'b0}});
  assign full      = (count_r == DEPTH_C);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array: cleared on reset so a discarded transfer leaves no stale bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {NB_DATA{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks push/pop balance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {NB_ADDR{1'b0}};
      rd_ptr_r <= {NB_ADDR{1'b0}};
      count_r  <= {(NB_ADDR + 1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them to the UART transmitter one at a time
// through the new_data / tx_done handshake, with sticky overflow/timeout flags.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int NB_DATA       = UART_NB_DATA,
  parameter int FIFO_DEPTH    = 16,
  parameter int NB_ADDR       = $clog2(FIFO_DEPTH),  // derived; do not override
  parameter int START_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_new_data,
  input  logic               i_tx_done,
  output logic [NB_ADDR:0]   o_count,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_overflow,
  output logic               o_timeout,
  input  logic               i_clr_flags,
  output logic               o_busy
);

  localparam int NB_TMO = $clog2(START_TIMEOUT) + 1;
  localparam logic [NB_TMO-1:0] TMO_LAST_C = NB_TMO'(START_TIMEOUT - 1);
  localparam logic [NB_TMO-1:0] TMO_ONE_C  = NB_TMO'(1);

  feed_state_e        state_r, state_nx_s;
  logic [NB_DATA-1:0] tx_data_r, tx_data_nx_s;
  logic               new_data_r, new_data_nx_s;
  logic [NB_TMO-1:0]  tmo_cnt_r, tmo_cnt_nx_s;
  logic               overflow_r, overflow_nx_s;
  logic               timeout_r, timeout_nx_s;
  logic               timeout_evt_s;
  logic               push_s;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [NB_DATA-1:0] fifo_head_s;

  // Ready depends only on the registered full flag, so a same-cycle pop never
  // makes room for a write.
  assign o_wr_ready    = !fifo_full_s;
  assign push_s        = i_wr_valid && !fifo_full_s;
  assign o_empty       = fifo_empty_s;
  assign o_full        = fifo_full_s;
  assign o_busy        = (state_r != FEED_IDLE) || !fifo_empty_s;
  assign o_tx_data     = tx_data_r;
  assign o_tx_new_data = new_data_r;
  assign o_overflow    = overflow_r;
  assign o_timeout     = timeout_r;

  uart_fifo #(
    .NB_DATA    (NB_DATA),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (i_wr_data),
    .rd_data (fifo_head_s),
    .count   (o_count),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s)
  );

  // Next-state, handshake, timeout counter and flag update logic.
  always_comb begin
    state_nx_s    = state_r;
    tx_data_nx_s  = tx_data_r;
    new_data_nx_s = new_data_r;
    tmo_cnt_nx_s  = tmo_cnt_r;
    timeout_evt_s = 1'b0;
    pop_s         = 1'b0;
    case (state_r)
      FEED_IDLE: begin
        if (!fifo_empty_s && i_tx_done) begin
          pop_s         = 1'b1;
          tx_data_nx_s  = fifo_head_s;
          new_data_nx_s = 1'b1;
          tmo_cnt_nx_s  = {NB_TMO{1'b0}};
          state_nx_s    = FEED_START;
        end else begin
          new_data_nx_s = 1'b0;
        end
      end
      FEED_START: begin
        if (!i_tx_done) begin
          new_data_nx_s = 1'b0;
          state_nx_s    = FEED_WAIT;
        end else if (tmo_cnt_r == TMO_LAST_C) begin
          // Transmitter never picked the byte up: abandon it.
          new_data_nx_s = 1'b0;
          timeout_evt_s = 1'b1;
          state_nx_s    = FEED_IDLE;
        end else begin
          tmo_cnt_nx_s  = tmo_cnt_r + TMO_ONE_C;
        end
      end
      FEED_WAIT: begin
        if (i_tx_done) begin
          state_nx_s = FEED_IDLE;
        end else begin
          state_nx_s = FEED_WAIT;
        end
      end
      default: begin
        new_data_nx_s = 1'b0;
        state_nx_s    = FEED_IDLE;
      end
    endcase

    // Set events take priority over a simultaneous clear.
    if (i_wr_valid && fifo_full_s) begin
      overflow_nx_s = 1'b1;
    end else if (i_clr_flags) begin
      overflow_nx_s = 1'b0;
    end else begin
      overflow_nx_s = overflow_r;
    end

    if (timeout_evt_s) begin
      timeout_nx_s = 1'b1;
    end else if (i_clr_flags) begin
      timeout_nx_s = 1'b0;
    end else begin
      timeout_nx_s = timeout_r;
    end
  end

  // State, output and flag registers; reset drops new_data at once.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= FEED_IDLE;
      tx_data_r  <= {NB_DATA{1'b0}};
      new_data_r <= 1'b0;
      tmo_cnt_r  <= {NB_TMO{1'b0}};
      overflow_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      tx_data_r  <= tx_data_nx_s;
      new_data_r <= new_data_nx_s;
      tmo_cnt_r  <= tmo_cnt_nx_s;
      overflow_r <= overflow_nx_s;
      timeout_r  <= timeout_nx_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a byte scoreboard is filled as bytes are
// accepted and a separate monitor checks every new_data request against it.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  logic       clk;
  logic       i_rst_n;
  logic [7:0] i_wr_data;
  logic       i_wr_valid;
  logic       o_wr_ready;
  logic [7:0] o_tx_data;
  logic       o_tx_new_data;
  logic       i_tx_done;
  logic [4:0] o_count;
  logic       o_empty;
  logic       o_full;
  logic       o_overflow;
  logic       o_timeout;
  logic       i_clr_flags;
  logic       o_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  uart_tx_feeder dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_wr_data     (i_wr_data),
    .i_wr_valid    (i_wr_valid),
    .o_wr_ready    (o_wr_ready),
    .o_tx_data     (o_tx_data),
    .o_tx_new_data (o_tx_new_data),
    .i_tx_done     (i_tx_done),
    .o_count       (o_count),
    .o_empty       (o_empty),
    .o_full        (o_full),
    .o_overflow    (o_overflow),
    .o_timeout     (o_timeout),
    .i_clr_flags   (i_clr_flags),
    .o_busy        (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte for one cycle; record it when it should be accepted.
  task automatic push_byte(input logic [7:0] b, input bit accept);
    i_wr_data  = b;
    i_wr_valid = 1'b1;
    if (accept) sb_q.push_back(b);
    tick();
    i_wr_valid = 1'b0;
  endtask

  // Transmitter model for one byte: wait for a request, go busy, go idle.
  task automatic serve_one();
    int n = 0;
    while (!o_tx_new_data && n < 50) begin
      tick();
      n++;
    end
    check("serve_request_seen", o_tx_new_data, 1);
    i_tx_done = 1'b0;
    tick();
    i_tx_done = 1'b1;
    tick();
  endtask

  // Monitor: every rising new_data must present the next scoreboard byte.
  initial begin
    logic prev_nd;
    logic [7:0] exp;
    prev_nd = 1'b0;
    forever begin
      @(negedge clk);
      if (!i_rst_n) begin
        prev_nd = 1'b0;
      end else begin
        if (o_tx_new_data && !prev_nd) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got byte %0h with empty scoreboard", o_tx_data);
          end else begin
            exp = sb_q.pop_front();
            if (o_tx_data !== exp) begin
              errors++;
              $display("FAIL tx_byte: got %0h expected %0h at %0t", o_tx_data, exp, $time);
            end
          end
        end
        prev_nd = o_tx_new_data;
      end
    end
  end

  initial begin
    i_rst_n     = 1'b0;
    i_wr_data   = 8'h00;
    i_wr_valid  = 1'b0;
    i_tx_done   = 1'b1;
    i_clr_flags = 1'b0;
    #2;
    // Reset values
    check("rst_tx_data", o_tx_data, 8'h00);
    check("rst_new_data", o_tx_new_data, 1'b0);
    check("rst_count", o_count, 5'd0);
    check("rst_empty", o_empty, 1'b1);
    check("rst_full", o_full, 1'b0);
    check("rst_wr_ready", o_wr_ready, 1'b1);
    check("rst_overflow", o_overflow, 1'b0);
    check("rst_timeout", o_timeout, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    // Writes during reset are ignored
    i_wr_data  = 8'h33;
    i_wr_valid = 1'b1;
    tick();
    check("rst_write_ignored", o_count, 5'd0);
    i_wr_valid = 1'b0;
    i_rst_n    = 1'b1;
    tick();

    // Single byte latency and handshake
    push_byte(8'hA5, 1'b1);
    check("lat_count_after_push", o_count, 5'd1);
    check("lat_no_request_yet", o_tx_new_data, 1'b0);
    check("lat_busy", o_busy, 1'b1);
    tick();
    check("lat_request", o_tx_new_data, 1'b1);
    check("lat_data", o_tx_data, 8'hA5);
    check("lat_count_popped", o_count, 5'd0);
    i_tx_done = 1'b0;
    tick();
    check("hs_request_cleared", o_tx_new_data, 1'b0);
    check("hs_busy_wait", o_busy, 1'b1);
    i_tx_done = 1'b1;
    tick();
    check("hs_idle", o_busy, 1'b0);

    // Fill to full with transmitter busy, then overflow
    i_tx_done = 1'b0;
    for (int i = 1; i <= 16; i++) push_byte(8'(i), 1'b1);
    check("fill_full", o_full, 1'b1);
    check("fill_count", o_count, 5'd16);
    check("fill_not_ready", o_wr_ready, 1'b0);
    push_byte(8'h11, 1'b0);
    check("ovf_flag", o_overflow, 1'b1);
    check("ovf_count", o_count, 5'd16);
    i_tx_done = 1'b1;
    for (int i = 0; i < 16; i++) serve_one();
    check("drain_empty", o_empty, 1'b1);
    check("ovf_sticky", o_overflow, 1'b1);
    i_clr_flags = 1'b1;
    tick();
    i_clr_flags = 1'b0;
    check("ovf_cleared", o_overflow, 1'b0);

    // Start timeout: transmitter never leaves idle
    push_byte(8'h5A, 1'b1);
    tick();
    check("tmo_request", o_tx_new_data, 1'b1);
    repeat (4095) tick();
    check("tmo_not_yet", o_timeout, 1'b0);
    check("tmo_still_request", o_tx_new_data, 1'b1);
    tick();
    check("tmo_flag", o_timeout, 1'b1);
    check("tmo_request_dropped", o_tx_new_data, 1'b0);
    check("tmo_byte_discarded", o_count, 5'd0);
    check("tmo_idle", o_busy, 1'b0);
    i_clr_flags = 1'b1;
    tick();
    i_clr_flags = 1'b0;
    check("tmo_cleared", o_timeout, 1'b0);

    // Steady push+pop at count 5
    i_tx_done = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h20 + i), 1'b1);
    check("steady_fill", o_count, 5'd5);
    for (int i = 0; i < 7; i++) begin
      i_tx_done = 1'b1;
      push_byte(8'(8'h30 + i), 1'b1);
      check("steady_count_a", o_count, 5'd5);
      i_tx_done = 1'b0;
      tick();
      check("steady_count_b", o_count, 5'd5);
      i_tx_done = 1'b1;
      tick();
      check("steady_count_c", o_count, 5'd5);
    end
    for (int i = 0; i < 5; i++) serve_one();
    check("steady_drained", o_empty, 1'b1);

    // Reset while a byte is being offered with 3 more queued
    i_tx_done = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h70 + i), 1'b1);
    i_tx_done = 1'b1;
    tick();
    check("mid_request", o_tx_new_data, 1'b1);
    check("mid_count", o_count, 5'd3);
    @(negedge clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("mid_rst_new_data", o_tx_new_data, 1'b0);
    check("mid_rst_tx_data", o_tx_data, 8'h00);
    check("mid_rst_count", o_count, 5'd0);
    check("mid_rst_empty", o_empty, 1'b1);
    check("mid_rst_busy", o_busy, 1'b0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    tick();
    check("mid_after_new_data", o_tx_new_data, 1'b0);
    check("mid_after_count", o_count, 5'd0);

    // Clear and overflow in the same cycle: set wins
    i_tx_done = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i), 1'b1);
    i_clr_flags = 1'b1;
    push_byte(8'hEE, 1'b0);
    i_clr_flags = 1'b0;
    check("clr_vs_ovf", o_overflow, 1'b1);
    check("clr_vs_ovf_count", o_count, 5'd16);
    i_clr_flags = 1'b1;
    tick();
    i_clr_flags = 1'b0;
    check("clr_alone", o_overflow, 1'b0);
    i_tx_done = 1'b1;
    for (int i = 0; i < 16; i++) serve_one();
    check("final_empty", o_empty, 1'b1);
    tick();
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
